// File: rtl/radio_ctrl.sv
// radio_ctrl: RC receiver supervisor. It watches per-channel pulse activity,
// arms and disarms on held stick gestures, drops into a failsafe when the link
// is lost, and registers the command word sent to the actuators.
// Optional feature macro: RADIO_CTRL_AUTO_EN. When it is defined, autopilot
// commands (auto_val) may replace the radio channels while armed. When it is
// not defined, auto_sel is tied low and the auto_* inputs are ignored.
module radio_ctrl #(
  parameter logic [19:0] TIMEOUT = 20'd100000,
  parameter logic [21:0] HOLD    = 22'd2000000,
  parameter logic [9:0]  STK_LO  = 10'd100,
  parameter logic [9:0]  STK_HI  = 10'd900,
  parameter logic [9:0]  FS_THR  = 10'd300
) (
  input  logic        tmr_1Mhz,
  input  logic        rst,
  input  logic [7:0]  radio_sig,
  input  logic [79:0] radio_val,
  input  logic [79:0] auto_val,
  input  logic        auto_valid,
  output logic [79:0] cmd_val,
  output logic [7:0]  link_ok,
  output logic        armed,
  output logic        failsafe,
  output logic        auto_sel
);

  typedef enum logic [2:0] {
    ST_DISARMED  = 3'd0,
    ST_ARMING    = 3'd1,
    ST_ARMED     = 3'd2,
    ST_DISARMING = 3'd3,
    ST_FAILSAFE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [21:0] hold_q, hold_d;
  logic [79:0] cmd_q, cmd_d;

  // Two flops for metastability plus one more to remember the previous value.
  logic [7:0] sig_meta_q, sig_sync_q, sig_prev_q;
  logic [7:0] sig_edge;

  logic [9:0] thr, yaw, mode;
  logic       link_up, arm_g, disarm_g, hold_last;

  // Synchronize the raw receiver pulse lines into the clock domain.
  always_ff @(posedge tmr_1Mhz) begin
    if (!rst) begin
      sig_meta_q <= '0;
      sig_sync_q <= '0;
      sig_prev_q <= '0;
    end else begin
      sig_meta_q <= radio_sig;
      sig_sync_q <= sig_meta_q;
      sig_prev_q <= sig_sync_q;
    end
  end

  assign sig_edge = sig_sync_q ^ sig_prev_q;

  // One saturating silence counter per channel; any pulse edge restarts it.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_link
      logic [19:0] cnt_q, cnt_d;

      // Clear on edge, otherwise count up until TIMEOUT and hold there.
      always_comb begin
        cnt_d = cnt_q;
        if (sig_edge[gi]) begin
          cnt_d = '0;
        end else if (cnt_q < TIMEOUT) begin
          cnt_d = cnt_q + 20'd1;
        end
      end

      // Counter register; starts at TIMEOUT so the link reads as down.
      always_ff @(posedge tmr_1Mhz) begin
        if (!rst) begin
          cnt_q <= TIMEOUT;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign link_ok[gi] = (cnt_q < TIMEOUT);
    end
  endgenerate

  // Only the first four channels are needed for flight.
  assign link_up = &link_ok[3:0];

  assign thr  = radio_val[29:20];
  assign yaw  = radio_val[39:30];
  assign mode = radio_val[49:40];

  assign arm_g     = (thr < STK_LO) && (yaw > STK_HI);
  assign disarm_g  = (thr < STK_LO) && (yaw < STK_LO);
  assign hold_last = (hold_q == (HOLD - 22'd1));

  // State and hold-counter registers.
  always_ff @(posedge tmr_1Mhz) begin
    if (!rst) begin
      state_q <= ST_DISARMED;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic; link loss always wins over gesture handling.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_DISARMED: begin
        if (arm_g && link_up) begin
          state_d = ST_ARMING;
          hold_d  = '0;
        end
      end
      ST_ARMING: begin
        if (!arm_g || !link_up) begin
          state_d = ST_DISARMED;
        end else if (hold_last) begin
          state_d = ST_ARMED;
        end else begin
          hold_d = hold_q + 22'd1;
        end
      end
      ST_ARMED: begin
        if (!link_up) begin
          state_d = ST_FAILSAFE;
        end else if (disarm_g) begin
          state_d = ST_DISARMING;
          hold_d  = '0;
        end
      end
      ST_DISARMING: begin
        if (!link_up) begin
          state_d = ST_FAILSAFE;
        end else if (!disarm_g) begin
          state_d = ST_ARMED;
        end else if (hold_last) begin
          state_d = ST_DISARMED;
        end else begin
          hold_d = hold_q + 22'd1;
        end
      end
      ST_FAILSAFE: begin
        if (link_up && (thr < STK_LO)) begin
          state_d = ST_DISARMED;
        end
      end
      default: begin
        state_d = ST_DISARMED;
        hold_d  = '0;
      end
    endcase
  end

  assign armed    = (state_q == ST_ARMED) || (state_q == ST_DISARMING);
  assign failsafe = (state_q == ST_FAILSAFE);

`ifdef RADIO_CTRL_AUTO_EN
  // Combinational so that losing auto_valid hands control back immediately.
  assign auto_sel = armed && (mode > 10'd500) && auto_valid;
`else
  logic unused_auto;
  assign unused_auto = ^{auto_val, auto_valid, mode};
  assign auto_sel    = 1'b0;
`endif

  // Select the actuator command from the current state.
  always_comb begin
    cmd_d = '0;
    case (state_q)
      ST_DISARMED, ST_ARMING: begin
        cmd_d          = radio_val;
        cmd_d[29:20]   = '0;
      end
      ST_ARMED, ST_DISARMING: begin
        cmd_d = auto_sel ? auto_val : radio_val;
      end
      ST_FAILSAFE: begin
        cmd_d        = '0;
        cmd_d[29:20] = FS_THR;
      end
      default: cmd_d = '0;
    endcase
  end

  // Command output register.
  always_ff @(posedge tmr_1Mhz) begin
    if (!rst) begin
      cmd_q <= '0;
    end else begin
      cmd_q <= cmd_d;
    end
  end

  assign cmd_val = cmd_q;

endmodule

// File: tb/tb_radio_ctrl.sv
// Testbench for radio_ctrl with short timeouts (HOLD=100, TIMEOUT=50).
// Expectations are queued as stimulus is applied and drained after the
// relevant clock edge.
module tb_radio_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  radio_sig;
  logic [79:0] radio_val;
  logic [79:0] auto_val;
  logic        auto_valid;
  logic [79:0] cmd_val;
  logic [7:0]  link_ok;
  logic        armed;
  logic        failsafe;
  logic        auto_sel;

  logic [7:0]  tog_en = 8'hFF;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_tog1 = 0;

  always #5 clk = ~clk;

  radio_ctrl #(
    .TIMEOUT(20'd50),
    .HOLD   (22'd100)
  ) dut (
    .tmr_1Mhz  (clk),
    .rst       (rst),
    .radio_sig (radio_sig),
    .radio_val (radio_val),
    .auto_val  (auto_val),
    .auto_valid(auto_valid),
    .cmd_val   (cmd_val),
    .link_ok   (link_ok),
    .armed     (armed),
    .failsafe  (failsafe),
    .auto_sel  (auto_sel)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver pulse activity: enabled channels toggle every 10 cycles.
  initial begin
    int ph;
    ph = 0;
    radio_sig = '0;
    forever begin
      @(posedge clk);
      #2;
      ph++;
      if (ph == 10) begin
        ph = 0;
        radio_sig = radio_sig ^ tog_en;
        if (tog_en[1]) last_tog1 = cyc;
      end
    end
  end

  typedef struct {
    string       tag;
    int          sel;
    logic [79:0] exp;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic sb_push(input string tag, input int sel, input logic [79:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // sel: 0 cmd_val, 1 armed, 2 failsafe, 3 link_ok, 4 auto_sel
  function automatic logic [79:0] observe(input int sel);
    case (sel)
      0:       return cmd_val;
      1:       return {79'd0, armed};
      2:       return {79'd0, failsafe};
      3:       return {72'd0, link_ok};
      default: return {79'd0, auto_sel};
    endcase
  endfunction

  task automatic sb_check();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ch(input int ch, input logic [9:0] v);
    radio_val[ch*10 +: 10] = v;
  endtask

  function automatic logic [79:0] no_thr(input logic [79:0] v);
    logic [79:0] r;
    r = v;
    r[29:20] = '0;
    return r;
  endfunction

  function automatic logic [79:0] fs_cmd();
    logic [79:0] r;
    r = '0;
    r[29:20] = 10'd300;
    return r;
  endfunction

  // Arm gesture: ARMING on edge 1, ARMED on edge 101.
  task automatic arm_seq(input string tag);
    set_ch(2, 10'd50);
    set_ch(3, 10'd950);
    for (int k = 1; k <= 101; k++) begin
      tick(1);
      if (k == 30) begin
        sb_push({tag, "_arming_cmd"}, 0, no_thr(radio_val));
        sb_check();
      end
      if (k == 100) begin
        sb_push({tag, "_armed_k100"}, 1, 80'd0);
        sb_check();
      end
    end
    sb_push({tag, "_armed_k101"}, 1, 80'd1);
    sb_check();
    set_ch(2, 10'd500);
    set_ch(3, 10'd500);
  endtask

  initial begin
    logic [79:0] exp_cmd;
    int          w;

    rst        = 1'b0;
    radio_val  = '0;
    auto_val   = '0;
    auto_valid = 1'b0;
    set_ch(0, 10'd512);
    set_ch(1, 10'd512);
    set_ch(2, 10'd500);
    set_ch(3, 10'd500);
    set_ch(4, 10'd0);
    set_ch(5, 10'd321);
    tick(3);
    sb_push("rst_cmd", 0, 80'd0);
    sb_push("rst_armed", 1, 80'd0);
    sb_push("rst_failsafe", 2, 80'd0);
    sb_push("rst_link_ok", 3, 80'd0);
    sb_push("rst_auto_sel", 4, 80'd0);
    sb_check();

    rst = 1'b1;
    tick(30);
    sb_push("link_up", 3, 80'hFF);
    sb_push("disarmed_cmd", 0, no_thr(radio_val));
    sb_push("disarmed_failsafe", 2, 80'd0);
    sb_check();

    // Gesture released after 60 cycles must not arm.
    set_ch(2, 10'd50);
    set_ch(3, 10'd950);
    tick(60);
    set_ch(2, 10'd500);
    set_ch(3, 10'd500);
    tick(5);
    sb_push("early_release_armed", 1, 80'd0);
    sb_check();

    arm_seq("arm1");

    // Armed: radio passes through with one cycle latency.
    set_ch(0, 10'd777);
    tick(1);
    sb_push("armed_cmd_radio", 0, radio_val);
    sb_check();

    // Autopilot takeover and handback.
    set_ch(4, 10'd800);
    auto_val       = '0;
    auto_val[9:0]  = 10'd123;
    auto_val[29:20] = 10'd456;
    auto_valid     = 1'b1;
    #1;
`ifdef RADIO_CTRL_AUTO_EN
    sb_push("auto_sel_on", 4, 80'd1);
    exp_cmd = auto_val;
`else
    sb_push("auto_sel_on", 4, 80'd0);
    exp_cmd = radio_val;
`endif
    sb_check();
    tick(1);
    sb_push("auto_cmd", 0, exp_cmd);
    sb_check();
    auto_valid = 1'b0;
    #1;
    sb_push("auto_sel_drop", 4, 80'd0);
    sb_check();
    tick(1);
    sb_push("auto_handback_cmd", 0, radio_val);
    sb_check();
    set_ch(4, 10'd0);

    // Disarm gesture held 99 cycles, then released: stays armed.
    set_ch(2, 10'd50);
    set_ch(3, 10'd50);
    tick(99);
    sb_push("disarming_armed", 1, 80'd1);
    sb_push("disarming_cmd", 0, radio_val);
    sb_check();
    set_ch(2, 10'd500);
    set_ch(3, 10'd500);
    tick(3);
    sb_push("disarm_abort_armed", 1, 80'd1);
    sb_check();

    // One-cycle reset pulse while armed.
    rst = 1'b0;
    tick(1);
    sb_push("rstpulse_armed", 1, 80'd0);
    sb_push("rstpulse_failsafe", 2, 80'd0);
    sb_push("rstpulse_cmd", 0, 80'd0);
    sb_push("rstpulse_link_ok", 3, 80'd0);
    sb_push("rstpulse_auto_sel", 4, 80'd0);
    sb_check();
    rst = 1'b1;
    tick(30);
    sb_push("post_rst_failsafe", 2, 80'd0);
    sb_push("post_rst_armed", 1, 80'd0);
    sb_push("post_rst_link_ok", 3, 80'hFF);
    sb_check();

    arm_seq("arm2");

    // Link loss on channel 1.
    tog_en = 8'hFD;
    w = 0;
    while (link_ok[1] && w < 100) begin
      tick(1);
      w++;
    end
    chk("link1_drop", {79'd0, link_ok[1]}, 80'd0);
    // Counter clears 3 edges after the last toggle, then needs 50 more.
    chk("link1_drop_cycle", 80'(cyc), 80'(last_tog1 + 53));
    sb_push("loss_failsafe_pre", 2, 80'd0);
    sb_check();
    tick(1);
    sb_push("loss_failsafe", 2, 80'd1);
    sb_push("loss_armed", 1, 80'd0);
    sb_check();
    tick(1);
    sb_push("failsafe_cmd", 0, fs_cmd());
    sb_check();

    // Link restored with throttle high: failsafe persists.
    tog_en = 8'hFF;
    set_ch(2, 10'd400);
    tick(30);
    sb_push("fs_hold_failsafe", 2, 80'd1);
    sb_push("fs_hold_link", 3, 80'hFF);
    sb_push("fs_hold_cmd", 0, fs_cmd());
    sb_check();

    // Throttle low exits failsafe to DISARMED.
    set_ch(2, 10'd50);
    tick(1);
    sb_push("fs_exit_failsafe", 2, 80'd0);
    sb_push("fs_exit_armed", 1, 80'd0);
    sb_check();
    tick(1);
    sb_push("fs_exit_cmd", 0, no_thr(radio_val));
    sb_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/radio_ctrl.md
RADIO_CTRL -- requirements
Module: radio_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 20'd100000, link-loss timeout in tmr_1Mhz cycles (100 ms).
REQ-002 SHALL have parameter HOLD, default 22'd2000000, stick-gesture hold time in cycles (2 s).
REQ-003 SHALL have parameter STK_LO, default 10'd100, low stick threshold.
REQ-004 SHALL have parameter STK_HI, default 10'd900, high stick threshold.
REQ-005 SHALL have parameter FS_THR, default 10'd300, failsafe throttle value.
REQ-006 SHALL have port tmr_1Mhz, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port radio_sig, input, 8 bits: raw, asynchronous receiver pulse lines, one per channel.
REQ-009 SHALL have port radio_val, input, 80 bits: decoded channels, channel i in bits [10i+9:10i].
REQ-010 SHALL have port auto_val, input, 80 bits: autopilot commands, same packing.
REQ-011 SHALL have port auto_valid, input, 1 bit: auto_val is usable.
REQ-012 SHALL have port cmd_val, output, 80 bits: registered command to actuators, same packing.
REQ-013 SHALL have port link_ok, output, 8 bits: per-channel pulse activity.
REQ-014 SHALL have port armed, output, 1 bit: state is ARMED or DISARMING.
REQ-015 SHALL have port failsafe, output, 1 bit: state is FAILSAFE.
REQ-016 SHALL have port auto_sel, output, 1 bit: cmd_val is sourced from auto_val.

Function
REQ-017 Channel map SHALL be: ch2 throttle, ch3 yaw, ch4 mode switch.
REQ-018 Each radio_sig bit SHALL be 2-flop synchronized; any edge of a synchronized bit SHALL clear that channel's counter.
REQ-019 Otherwise the counter SHALL increment, saturating at TIMEOUT; link_ok[i] SHALL be 1 iff counter < TIMEOUT.
REQ-020 link_up SHALL equal &link_ok[3:0].
REQ-021 The FSM SHALL have states DISARMED, ARMING, ARMED, DISARMING, FAILSAFE.
REQ-022 arm_g SHALL be (thr < STK_LO) and (yaw > STK_HI).
REQ-023 disarm_g SHALL be (thr < STK_LO) and (yaw < STK_LO).
REQ-024 DISARMED SHALL go to ARMING when arm_g and link_up; the hold counter SHALL be cleared on entry.
REQ-025 ARMING SHALL increment the hold counter each cycle; it SHALL go to ARMED when count = HOLD-1 with arm_g still true, and to DISARMED if arm_g or link_up drops.
REQ-026 ARMED SHALL go to FAILSAFE when !link_up (priority), else to DISARMING when disarm_g; the hold counter SHALL be cleared.
REQ-027 DISARMING SHALL go to FAILSAFE when !link_up (priority), to DISARMED when count = HOLD-1 with disarm_g, and back to ARMED if disarm_g drops.
REQ-028 FAILSAFE SHALL go to DISARMED only when link_up and thr < STK_LO in the same cycle.
REQ-029 auto_sel SHALL be 1 iff armed and radio ch4 > 10'd500 and auto_valid; it SHALL drop in the same cycle auto_valid drops.
REQ-030 cmd_val SHALL be registered with 1-cycle latency from the inputs and the current state.
REQ-031 In DISARMED and ARMING, cmd_val SHALL be radio_val with ch2 forced to 0.
REQ-032 In ARMED and DISARMING, cmd_val SHALL be auto_val if auto_sel, else radio_val.
REQ-033 In FAILSAFE, cmd_val SHALL be all channels 0 except ch2 = FS_THR.
REQ-034 Comparisons SHALL be unsigned 10-bit.
REQ-035 Counters SHALL never wrap.

Reset
REQ-036 While rst=0: state DISARMED, cmd_val 0, armed 0, failsafe 0, auto_sel 0, hold counter 0, link counters at TIMEOUT (link_ok 0), synchronizers 0.
REQ-037 Reset asserted mid-ARMED SHALL disarm on the next edge; no failsafe SHALL be entered on reset release.

Configuration
REQ-038 With RADIO_CTRL_AUTO_EN defined, auto_sel and the auto_val path SHALL behave per REQ-029 and REQ-032.
REQ-039 With RADIO_CTRL_AUTO_EN undefined, auto_sel SHALL be tied 0 and auto_val/auto_valid ignored; the ports SHALL remain present.

Verification
REQ-040 Run with HOLD=100, TIMEOUT=50 and 1 kHz-equivalent toggling on all channels: thr=50, yaw=950 held 100 cycles -> armed=1 exactly 101 cycles after gesture start; release at cycle 60 -> remains DISARMED.
REQ-041 When armed, stop radio_sig[1] toggling -> link_ok[1]=0 after 50 cycles; failsafe=1 next cycle; cmd_val ch2=300, others 0.
REQ-042 In FAILSAFE, restore toggling with thr=400 -> stays FAILSAFE; set thr=50 -> DISARMED, cmd_val ch2=0.
REQ-043 When armed, ch4=800, auto_valid=1, auto ch0=123 -> cmd_val ch0=123 one cycle later; auto_valid=0 -> radio ch0 next cycle; macro undefined -> always radio.
REQ-044 When armed, assert disarm_g for 99 cycles then release -> stays ARMED; pulse rst=0 for one cycle while armed -> all outputs 0, DISARMED.
